// File: rtl/hex_display_ctrl.sv
// Multi-digit hexadecimal display controller for active-low 7-segment pins.
// A packed value is captured on a load handshake and converted one digit per
// cycle, most significant first, through one shared decoder into per-digit
// segment registers. Optional leading-zero blanking and per-digit blinking.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int BLINK_W    = 25
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      lz_blank,
    input  logic                      blink_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic                      ready,
    output logic [7*NUM_DIGITS-1:0]   hex
);

    localparam int         IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Shared hex-to-segment decoder, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_nibble(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Conversion state.
    state_t                    r_state;
    logic [4*NUM_DIGITS-1:0]   r_val;
    logic                      r_lz;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_lead;
    logic [6:0]                r_seg [NUM_DIGITS];

    // Blink timebase.
    logic [BLINK_W-1:0]        r_bcnt;
    logic                      r_phase;

    // Next-state / datapath control.
    state_t                    w_state_nxt;
    logic [4*NUM_DIGITS-1:0]   w_val_nxt;
    logic                      w_lz_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      w_lead_nxt;
    logic                      w_seg_we;
    logic [6:0]                w_seg_wdata;
    logic [3:0]                w_nibble;
    logic                      w_blank_digit;
    logic                      w_bcnt_wrap;

    // Nibble currently being converted and whether it is a blankable leading zero.
    assign w_nibble      = r_val[4*int'(r_idx) +: 4];
    assign w_blank_digit = r_lz && r_lead && (w_nibble == 4'h0) && (r_idx != '0);
    assign w_bcnt_wrap   = (r_bcnt == BLINK_W'(BLINK_DIV - 1));

    assign ready = (r_state == S_IDLE);

    // Next-state logic: capture in IDLE, one digit write per cycle in CONV.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_lz_nxt    = r_lz;
        w_idx_nxt   = r_idx;
        w_lead_nxt  = r_lead;
        w_seg_we    = 1'b0;
        w_seg_wdata = SEG_BLANK;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_val_nxt   = value;
                    w_lz_nxt    = lz_blank;
                    w_idx_nxt   = IDX_W'(NUM_DIGITS - 1);
                    w_lead_nxt  = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_seg_we = 1'b1;
                if (w_blank_digit) begin
                    w_seg_wdata = SEG_BLANK;
                end else begin
                    w_seg_wdata = decode_nibble(w_nibble);
                    w_lead_nxt  = 1'b0;
                end
                if (r_idx == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM and capture registers.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!resetn) begin
            r_state <= S_IDLE;
            r_val   <= '0;
            r_lz    <= 1'b0;
            r_idx   <= '0;
            r_lead  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_lz    <= w_lz_nxt;
            r_idx   <= w_idx_nxt;
            r_lead  <= w_lead_nxt;
        end
    end

    // Per-digit segment registers, written in place by the converter.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: this small register array is reset deliberately: the display must
        // go dark at once on reset and an aborted conversion must leave no digits.
        if (!resetn) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_seg[k] <= SEG_BLANK;
            end
        end else if (w_seg_we) begin
            r_seg[r_idx] <= w_seg_wdata;
        end
    end

    // Free-running blink counter; phase flips on every wrap.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_bcnt_wrap) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    // Output mux: blinking digits are forced dark during the active phase.
    always_comb begin
        hex = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blink_en && blink_mask[k] && r_phase) begin
                hex[7*k +: 7] = SEG_BLANK;
            end else begin
                hex[7*k +: 7] = r_seg[k];
            end
        end
    end

endmodule
